// File: rtl/branch_backup_ctrl.sv
// Branch-backup FIFO sequencer: pushes the path opposite to each prediction,
// retires entries on correct resolution and redirects fetch on a mispredict.
module branch_backup_ctrl #(
  parameter int PC_W  = 11,
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             fetch_branch,
  input  logic             predict_taken,
  input  logic             resolve_valid,
  input  logic             resolve_taken,
  input  logic [PC_W-1:0]  fifo_p,
  output logic             fifo_push,
  output logic             fifo_pop,
  output logic             fifo_enable,
  output logic             fifo_select,
  output logic             fifo_clear,
  output logic             fetch_stall,
  output logic             redirect_valid,
  output logic [PC_W-1:0]  redirect_pc,
  output logic             flush,
  output logic             err_underflow,
  output logic [CNT_W-1:0] mispredict_cnt
);

  localparam int OCC_W = $clog2(DEPTH + 1);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t           state_q, state_d;
  logic [OCC_W-1:0] count_q, count_d;
  logic [DEPTH-1:0] dir_q, dir_d;
  logic [PC_W-1:0]  redirect_pc_q, redirect_pc_d;
  logic             redirect_valid_q, redirect_valid_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] mcnt_q, mcnt_d;

  logic             full, empty, run, resolve_ok;
  logic             mispredict_now, correct_now, push_en;
  logic [OCC_W-1:0] tail;
  logic [DEPTH-1:0] dir_shift;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign full           = (count_q == OCC_W'(DEPTH));
  assign empty          = (count_q == '0);
  assign run            = (state_q == RUN);
  assign resolve_ok     = run && resolve_valid && !empty;
  assign mispredict_now = resolve_ok && (resolve_taken != dir_q[0]);
  assign correct_now    = resolve_ok && (resolve_taken == dir_q[0]);
  // A branch fetched alongside a mispredict is on the wrong path: drop it.
  assign push_en        = run && fetch_branch && !full && !mispredict_now;

  always_comb begin
    state_d          = state_q;
    count_d          = count_q + OCC_W'(push_en) - OCC_W'(correct_now);
    redirect_pc_d    = redirect_pc_q;
    redirect_valid_d = redirect_valid_q;
    err_d            = err_q;
    mcnt_d           = mcnt_q;
    // Head is bit 0; a pop shifts before the new direction lands at the tail.
    dir_shift        = correct_now ? (dir_q >> 1) : dir_q;
    tail             = count_q - OCC_W'(correct_now);
    dir_d            = dir_shift;
    for (int i = 0; i < DEPTH; i++) begin
      if (push_en && (tail == OCC_W'(i))) dir_d[i] = predict_taken;
    end
    case (state_q)
      RUN: begin
        if (mispredict_now) begin
          state_d          = FLUSH;
          redirect_pc_d    = fifo_p;
          redirect_valid_d = 1'b1;
          mcnt_d           = sat_inc(mcnt_q);
        end
        if (resolve_valid && empty) err_d = 1'b1;
      end
      FLUSH: begin
        state_d          = RUN;
        count_d          = '0;
        dir_d            = '0;
        redirect_valid_d = 1'b0;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q          <= RUN;
      count_q          <= '0;
      dir_q            <= '0;
      redirect_pc_q    <= '0;
      redirect_valid_q <= 1'b0;
      err_q            <= 1'b0;
      mcnt_q           <= '0;
    end else begin
      state_q          <= state_d;
      count_q          <= count_d;
      dir_q            <= dir_d;
      redirect_pc_q    <= redirect_pc_d;
      redirect_valid_q <= redirect_valid_d;
      err_q            <= err_d;
      mcnt_q           <= mcnt_d;
    end
  end

  // Input-driven strobes are masked while clear is held so the FIFO sees only the clear.
  always_comb begin
    fifo_enable    = !clear && fetch_branch;
    fifo_select    = !clear && predict_taken;
    fifo_push      = !clear && push_en;
    fifo_pop       = !clear && correct_now;
    fetch_stall    = !clear && fetch_branch && (full || (state_q == FLUSH));
    fifo_clear     = clear || (state_q == FLUSH);
    flush          = (state_q == FLUSH);
    redirect_valid = redirect_valid_q;
    redirect_pc    = redirect_pc_q;
    err_underflow  = err_q;
    mispredict_cnt = mcnt_q;
  end

endmodule
